// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs one IR or DR scan per accepted request and returns the captured TDO bits.
// The TAP is reset once after rst_i and is always left parked in Run-Test/Idle between scans.
module jtag_scan_master #(
  parameter int unsigned IR_LEN  = 5,
  parameter int unsigned DR_MAX  = 41,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned LW = $clog2(DR_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_ir_i,
  input  logic [LW-1:0]     req_len_i,
  input  logic [DR_MAX-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DR_MAX-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {StInitRst, StIdle, StPre, StShift, StPost, StResp} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [2:0]        per_q, per_d;
  logic [LW-1:0]     cnt_q, cnt_d, len_q, len_d;
  logic              ir_q, ir_d;
  logic [DR_MAX-1:0] sh_q, sh_d, rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;

  logic tick, active, rise, fall, len_bad;

  assign active  = (state_q == StInitRst) || (state_q == StPre) ||
                   (state_q == StShift) || (state_q == StPost);
  assign tick    = (div_q == DW'(CLK_DIV - 1));
  assign rise    = active && tick && !tck_q;
  assign fall    = active && tick && tck_q;
  assign len_bad = req_ir_i ? (32'(req_len_i) != IR_LEN)
                            : ((req_len_i == '0) || (32'(req_len_i) > DR_MAX));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StInitRst;
      div_q      <= '0;
      per_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ir_q       <= 1'b0;
      sh_q       <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      per_q      <= per_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ir_q       <= ir_d;
      sh_q       <= sh_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
    end
  end

  // TMS/TDI for the next period are set on the falling-TCK edge that ends the current one.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    per_d      = per_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ir_d       = ir_q;
    sh_d       = sh_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    if (active) begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) tck_d = ~tck_q;
    end
    unique case (state_q)
      StInitRst: begin
        if (fall) begin
          if (per_q == 3'd5) begin
            state_d = StIdle;
            per_d   = '0;
          end else begin
            per_d = per_q + 3'd1;
            tms_d = (per_q < 3'd4);
          end
        end
      end
      StIdle: begin
        if (req_valid_i) begin
          ir_d       = req_ir_i;
          len_d      = req_len_i;
          sh_d       = req_data_i;
          rsp_data_d = '0;
          div_d      = '0;
          per_d      = '0;
          cnt_d      = '0;
          err_d      = len_bad;
          if (len_bad) begin
            state_d = StResp;
          end else begin
            state_d = StPre;
            tms_d   = 1'b1;
          end
        end
      end
      StPre: begin
        if (fall) begin
          if (per_q == (ir_q ? 3'd3 : 3'd2)) begin
            state_d = StShift;
            per_d   = '0;
            tms_d   = (len_q == LW'(1));
            tdi_d   = sh_q[0];
          end else begin
            per_d = per_q + 3'd1;
            tms_d = ir_q && (per_q == 3'd0);
          end
        end
      end
      StShift: begin
        if (rise) rsp_data_d[cnt_q] = tdo_i;
        if (fall) begin
          if (cnt_q + LW'(1) == len_q) begin
            state_d = StPost;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + LW'(1);
            sh_d  = sh_q >> 1;
            tdi_d = sh_d[0];
            tms_d = (cnt_q + LW'(2) == len_q);
          end
        end
      end
      StPost: begin
        if (fall) begin
          if (per_q == 3'd1) begin
            state_d = StResp;
            per_d   = '0;
          end else begin
            per_d = 3'd1;
            tms_d = 1'b0;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StInitRst;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == StIdle);
    rsp_valid_o = (state_q == StResp);
    rsp_err_o   = err_q && (state_q == StResp);
    rsp_data_o  = rsp_data_q;
    tck_o       = tck_q;
    tms_o       = tms_q;
    tdi_o       = tdi_q;
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural 1149.1 TAP (IDCODE, 5-bit IR) or a TDI->TDO
// one-period loopback sits on the pins; scan results are predicted from the scan rules.
module tb_jtag_scan_master;
  localparam int IR_LEN  = 5;
  localparam int DR_MAX  = 41;
  localparam int CLK_DIV = 2;
  localparam int LW      = $clog2(DR_MAX + 1);
  localparam logic [31:0] IdcodeVal = 32'h0BA00477;
  localparam logic [4:0]  IdcodeOp  = 5'h1E;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ir = 1'b0, rsp_ready = 1'b0;
  logic [LW-1:0] req_len = '0;
  logic [DR_MAX-1:0] req_data = '0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, tck_o, tms_o, tdi_o, tdo;
  logic [DR_MAX-1:0] rsp_data_o;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_ir_i(req_ir), .req_len_i(req_len), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo)
  );

  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauseDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauseIr, TapEx2Ir, TapUpdIr
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic t);
    case (s)
      TapTlr:     return t ? TapTlr   : TapRti;
      TapRti:     return t ? TapSelDr : TapRti;
      TapSelDr:   return t ? TapSelIr : TapCapDr;
      TapCapDr:   return t ? TapEx1Dr : TapShDr;
      TapShDr:    return t ? TapEx1Dr : TapShDr;
      TapEx1Dr:   return t ? TapUpdDr : TapPauseDr;
      TapPauseDr: return t ? TapEx2Dr : TapPauseDr;
      TapEx2Dr:   return t ? TapUpdDr : TapShDr;
      TapUpdDr:   return t ? TapSelDr : TapRti;
      TapSelIr:   return t ? TapTlr   : TapCapIr;
      TapCapIr:   return t ? TapEx1Ir : TapShIr;
      TapShIr:    return t ? TapEx1Ir : TapShIr;
      TapEx1Ir:   return t ? TapUpdIr : TapPauseIr;
      TapPauseIr: return t ? TapEx2Ir : TapPauseIr;
      TapEx2Ir:   return t ? TapUpdIr : TapShIr;
      default:    return t ? TapSelDr : TapRti;
    endcase
  endfunction

  tap_e tap_st = TapTlr;
  logic [4:0]  tap_ir = IdcodeOp, ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic tap_tdo = 1'b0, lb_a = 1'b0, lb_tdo = 1'b0, loopback = 1'b0;
  int   tck_cnt = 0;
  logic tms_log[$];
  logic tdi_log[$];

  always @(posedge tck_o) begin
    tck_cnt++;
    tms_log.push_back(tms_o);
    tdi_log.push_back(tdi_o);
    lb_a <= tdi_o;
    case (tap_st)
      TapTlr:   tap_ir <= IdcodeOp;
      TapCapDr: dr_sr  <= (tap_ir == IdcodeOp) ? IdcodeVal : 32'h0;
      TapShDr:  dr_sr  <= (tap_ir == IdcodeOp) ? {tdi_o, dr_sr[31:1]} : {31'h0, tdi_o};
      TapCapIr: ir_sr  <= 5'b00001;
      TapShIr:  ir_sr  <= {tdi_o, ir_sr[4:1]};
      TapUpdIr: tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms_o);
  end

  always @(negedge tck_o) begin
    lb_tdo  <= lb_a;
    tap_tdo <= (tap_st == TapShDr) ? dr_sr[0] : (tap_st == TapShIr) ? ir_sr[0] : 1'b0;
  end

  assign tdo = loopback ? lb_tdo : tap_tdo;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // TMS per TCK period: prefix walks Idle->Shift, shift exits on its last bit, postfix Update->Idle.
  function automatic logic [63:0] exp_tms(input bit ir, input int len);
    logic [63:0] v;
    int k;
    v = '0;
    v[0] = 1'b1;
    if (ir) v[1] = 1'b1;
    k = ir ? 4 : 3;
    v[k + len - 1] = 1'b1;
    v[k + len] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] tms_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < tms_log.size() && k < 64; k++) v[k] = tms_log[k];
    return v;
  endfunction

  function automatic logic [DR_MAX-1:0] loop_exp(input logic [DR_MAX-1:0] d, input int len);
    logic [DR_MAX-1:0] e;
    e = '0;
    for (int b = 1; b < len; b++) e[b] = d[b-1];
    return e;
  endfunction

  task automatic do_scan(input bit ir, input int len, input logic [DR_MAX-1:0] data,
                         output logic [DR_MAX-1:0] rd, output logic err, output int lat);
    int n;
    n = 0;
    while (!req_ready_o && n < 1000) begin @(negedge clk); n++; end
    tck_cnt = 0;
    tms_log.delete();
    tdi_log.delete();
    req_valid = 1'b1;
    req_ir    = ir;
    req_len   = LW'(len);
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_ir    = 1'($urandom);
    req_len   = LW'($urandom);
    req_data  = DR_MAX'({$urandom, $urandom});
    lat = 1;
    while (!rsp_valid_o && lat < 3000) begin @(negedge clk); lat++; end
    checks++;
    if (rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL scan_timeout rsp_valid=%b after %0d cycles, want 1", rsp_valid_o, lat);
    end
    rd  = rsp_data_o;
    err = rsp_err_o;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o, rsp_err_o} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_pins got %b want 010000",
               {tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o, rsp_err_o});
    end
    checks++;
    if (rsp_data_o !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", rsp_data_o);
    end
    tck_cnt = 0; tms_log.delete(); tdi_log.delete();
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o && n < 200);
    checks++;
    if (n !== 24) begin errors++; $display("FAIL reset_ready_delay got %0d want 24", n); end
    checks++;
    if (tck_cnt !== 6) begin errors++; $display("FAIL reset_tck_count got %0d want 6", tck_cnt); end
    checks++;
    if (tms_vec() !== 64'h1F) begin
      errors++; $display("FAIL reset_tms_seq got %h want 1f", tms_vec());
    end
    checks++;
    if (tap_st !== TapRti) begin errors++; $display("FAIL reset_tap_state got %0d want %0d", tap_st, TapRti); end
  endtask

  task automatic test_idcode();
    logic [DR_MAX-1:0] rd; logic err; int lat;
    loopback = 1'b0;
    do_scan(1'b0, 32, '0, rd, err, lat);
    checks++;
    if (rd !== DR_MAX'(IdcodeVal)) begin errors++; $display("FAIL idcode_data got %h want %h", rd, IdcodeVal); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL idcode_err got %b want 0", err); end
    checks++;
    if (tck_cnt !== 37) begin errors++; $display("FAIL idcode_tck_count got %0d want 37", tck_cnt); end
    checks++;
    if (tms_vec() !== exp_tms(1'b0, 32)) begin
      errors++; $display("FAIL idcode_tms_seq got %h want %h", tms_vec(), exp_tms(1'b0, 32));
    end
  endtask

  task automatic test_ir_scan();
    logic [DR_MAX-1:0] rd; logic err; int lat;
    loopback = 1'b0;
    do_scan(1'b1, IR_LEN, DR_MAX'(5'h11), rd, err, lat);
    checks++;
    if (tap_ir !== 5'h11) begin errors++; $display("FAIL ir_loaded got %h want 11", tap_ir); end
    checks++;
    if (rd !== DR_MAX'(5'b00001)) begin errors++; $display("FAIL ir_capture got %h want 1", rd); end
    checks++;
    if (tck_cnt !== 11) begin errors++; $display("FAIL ir_tck_count got %0d want 11", tck_cnt); end
    checks++;
    if ({err, tap_st} !== {1'b0, TapRti}) begin
      errors++; $display("FAIL ir_err_state got err=%b st=%0d want err=0 st=%0d", err, tap_st, TapRti);
    end
  endtask

  task automatic test_len_errors();
    logic [DR_MAX-1:0] rd; logic err; int lat;
    bit ir_c[4]; int len_c[4];
    ir_c  = '{1'b0, 1'b0, 1'b1, 1'b1};
    len_c = '{0, DR_MAX + 1, IR_LEN - 1, IR_LEN + 1};
    for (int i = 0; i < 4; i++) begin
      do_scan(ir_c[i], len_c[i], DR_MAX'({$urandom, $urandom}) | DR_MAX'(1), rd, err, lat);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL lenerr_flag[%0d] got %b want 1", i, err); end
      checks++;
      if (rd !== '0) begin errors++; $display("FAIL lenerr_data[%0d] got %h want 0", i, rd); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL lenerr_latency[%0d] got %0d want 1", i, lat); end
      checks++;
      if (tck_cnt !== 0) begin errors++; $display("FAIL lenerr_tck[%0d] got %0d want 0", i, tck_cnt); end
    end
  endtask

  task automatic test_random_loopback();
    logic [DR_MAX-1:0] data, rd;
    logic [63:0] r;
    logic err;
    int lat, len, npre, nper;
    bit ir, tdi_ok;
    loopback = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ir   = (i > 1) && ($urandom_range(0, 3) == 0);
      len  = (i == 0) ? 1 : (i == 1) ? DR_MAX : ir ? IR_LEN : int'($urandom_range(1, DR_MAX));
      r    = {$urandom, $urandom};
      data = r[DR_MAX-1:0];
      npre = ir ? 4 : 3;
      nper = npre + len + 2;
      do_scan(ir, len, data, rd, err, lat);
      rd[0] = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rand_err[%0d] got %b want 0", i, err); end
      checks++;
      if (rd !== loop_exp(data, len)) begin
        errors++; $display("FAIL rand_data[%0d] len=%0d got %h want %h", i, len, rd, loop_exp(data, len));
      end
      checks++;
      if (tck_cnt !== nper) begin errors++; $display("FAIL rand_tck[%0d] got %0d want %0d", i, tck_cnt, nper); end
      checks++;
      if (lat !== 2 * CLK_DIV * nper + 1) begin
        errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, 2 * CLK_DIV * nper + 1);
      end
      checks++;
      if (tms_vec() !== exp_tms(ir, len)) begin
        errors++; $display("FAIL rand_tms[%0d] got %h want %h", i, tms_vec(), exp_tms(ir, len));
      end
      tdi_ok = 1'b1;
      for (int k = 0; k < len; k++)
        if (tdi_log.size() <= npre + k || tdi_log[npre + k] !== data[k]) tdi_ok = 1'b0;
      checks++;
      if (!tdi_ok) begin errors++; $display("FAIL rand_tdi[%0d] got mismatching bits want %h", i, data); end
      checks++;
      if (tap_st !== TapRti) begin errors++; $display("FAIL rand_tap_state[%0d] got %0d want %0d", i, tap_st, TapRti); end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [DR_MAX-1:0] data, rd; logic [63:0] r; logic err; int lat, n; bit seen;
    loopback = 1'b1;
    n = 0;
    while (!req_ready_o && n < 1000) begin @(negedge clk); n++; end
    tck_cnt = 0;
    req_valid = 1'b1; req_ir = 1'b0; req_len = LW'(DR_MAX); req_data = DR_MAX'({$urandom, $urandom});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (tck_cnt < 13 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (tck_cnt < 13) begin errors++; $display("FAIL midrst_reach_shift got %0d tcks want 13", tck_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tck_o, tms_o, req_ready_o, rsp_valid_o} !== 4'b0100) begin
      errors++; $display("FAIL midrst_pins got %b want 0100", {tck_o, tms_o, req_ready_o, rsp_valid_o});
    end
    rst = 1'b0;
    tck_cnt = 0; tms_log.delete(); tdi_log.delete();
    n = 0; seen = 1'b0;
    do begin
      @(negedge clk); n++;
      if (rsp_valid_o) seen = 1'b1;
    end while (!req_ready_o && n < 200);
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_no_rsp got rsp_valid=1 want 0"); end
    checks++;
    if (n !== 24) begin errors++; $display("FAIL midrst_ready_delay got %0d want 24", n); end
    checks++;
    if (tms_vec() !== 64'h1F) begin errors++; $display("FAIL midrst_tms_seq got %h want 1f", tms_vec()); end
    r = {$urandom, $urandom};
    data = r[DR_MAX-1:0];
    do_scan(1'b0, DR_MAX, data, rd, err, lat);
    rd[0] = 1'b0;
    checks++;
    if ({err, rd} !== {1'b0, loop_exp(data, DR_MAX)}) begin
      errors++; $display("FAIL midrst_rescan got err=%b %h want err=0 %h", err, rd, loop_exp(data, DR_MAX));
    end
  endtask

  task automatic test_back_to_back();
    logic [DR_MAX-1:0] da, db, got; logic [63:0] r; int n;
    int la, lb;
    la = 20; lb = 33;
    loopback = 1'b1;
    r = {$urandom, $urandom}; da = r[DR_MAX-1:0];
    r = {$urandom, $urandom}; db = r[DR_MAX-1:0];
    n = 0;
    while (!req_ready_o && n < 1000) begin @(negedge clk); n++; end
    tck_cnt = 0;
    req_valid = 1'b1; req_ir = 1'b0; req_len = LW'(la); req_data = da;
    @(negedge clk);
    req_len = LW'(lb); req_data = db;
    n = 0;
    while (!rsp_valid_o && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got %b want 1", rsp_valid_o); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got = rsp_data_o; got[0] = 1'b0;
      checks++;
      if ({rsp_valid_o, rsp_err_o, req_ready_o} !== 3'b100) begin
        errors++; $display("FAIL b2b_hold_flags[%0d] got %b want 100", c, {rsp_valid_o, rsp_err_o, req_ready_o});
      end
      checks++;
      if (got !== loop_exp(da, la)) begin
        errors++; $display("FAIL b2b_hold_data[%0d] got %h want %h", c, got, loop_exp(da, la));
      end
      checks++;
      if (tck_cnt !== la + 5) begin errors++; $display("FAIL b2b_hold_tck[%0d] got %0d want %0d", c, tck_cnt, la + 5); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tck_cnt = 0;
    n = 0;
    while (!req_ready_o && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_data = DR_MAX'({$urandom, $urandom});
    n = 0;
    while (!rsp_valid_o && n < 3000) begin @(negedge clk); n++; end
    got = rsp_data_o; got[0] = 1'b0;
    checks++;
    if (got !== loop_exp(db, lb)) begin
      errors++; $display("FAIL b2b_second_data got %h want %h", got, loop_exp(db, lb));
    end
    checks++;
    if (tck_cnt !== lb + 5) begin errors++; $display("FAIL b2b_second_tck got %0d want %0d", tck_cnt, lb + 5); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_scan();
    test_len_errors();
    test_random_loopback();
    test_reset_mid_scan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
